// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: state codes read by vga_top,
// alien count, score width and the saturating score adder.
package game_pkg;
    localparam int NUM_ALIENS = 6;
    localparam int SCORE_W    = 8;

    localparam logic [2:0] ST_ATTRACT    = 3'd0;
    localparam logic [2:0] ST_WAVE_RESET = 3'd1;
    localparam logic [2:0] ST_PLAYING    = 3'd2;
    localparam logic [2:0] ST_WAVE_CLEAR = 3'd3;
    localparam logic [2:0] ST_LIFE_LOST  = 3'd4;
    localparam logic [2:0] ST_GAME_OVER  = 3'd5;
    localparam logic [2:0] ST_VICTORY    = 3'd6;

    // Score sticks at all ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add_score(input logic [SCORE_W-1:0] score,
                                                         input logic [SCORE_W-1:0] inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, score} + {1'b0, inc};
        if (sum[SCORE_W]) begin
            return '1;
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction
endpackage

// File: rtl/popcount_kills.sv
// Counts aliens that were alive last cycle and are dead now.
module popcount_kills #(
    parameter int N = 6,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] alive_i,
    input  logic [N-1:0] index_i,
    output logic [W-1:0] kills_o
);

    // Sum of alive-to-dead transitions across all alien slots.
    always_comb begin
        kills_o = '0;
        for (int i = 0; i < N; i++) begin
            kills_o = kills_o + W'(alive_i[i] & ~index_i[i]);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game flow controller: attract, wave reset, play, wave clear, life lost,
// game over and victory, with lives, level and saturating score bookkeeping.
module game_sequencer #(
    parameter int NUM_ALIENS    = game_pkg::NUM_ALIENS,
    parameter int START_LIVES   = 3,
    parameter int MAX_LEVEL     = 4,
    parameter int BANNER_FRAMES = 120,
    parameter int BASE_DIV      = 24,
    parameter int DIV_STEP      = 4
) (
    input  logic                  master_clk,
    input  logic                  d_reset_n,
    input  logic                  d_fire,
    input  logic                  frame_tick,
    input  logic [NUM_ALIENS-1:0] index_aliens,
    input  logic                  alien_landed,
    output logic                  wave_rst,
    output logic                  play_en,
    output logic [2:0]            level,
    output logic [7:0]            alien_div,
    output logic [1:0]            lives,
    output logic [7:0]            total_score,
    output logic                  game_over,
    output logic                  victory,
    output logic [2:0]            state_code
);
    import game_pkg::*;

    localparam int KILL_W   = $clog2(NUM_ALIENS + 1);
    localparam int BANNER_W = $clog2(BANNER_FRAMES + 1);

    logic [2:0]            state_q, state_d;
    logic [1:0]            lives_q, lives_d;
    logic [2:0]            level_q, level_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic [NUM_ALIENS-1:0] alive_q, alive_d;
    logic [BANNER_W-1:0]   banner_q, banner_d;
    logic                  wr_cnt_q, wr_cnt_d;
    logic                  fire_q;

    logic                  wave_rst_q, play_en_q, game_over_q, victory_q;
    logic [2:0]            level_out_q, state_code_q;
    logic [7:0]            alien_div_q, div_s;
    logic [1:0]            lives_out_q;
    logic [SCORE_W-1:0]    score_out_q;

    logic                  fire_edge_s, banner_done_s;
    logic [KILL_W-1:0]     kills_s;

    popcount_kills #(.N(NUM_ALIENS), .W(KILL_W)) u_kills (
        .alive_i (alive_q),
        .index_i (index_aliens),
        .kills_o (kills_s)
    );

    assign fire_edge_s   = d_fire & ~fire_q;
    assign banner_done_s = frame_tick && (banner_q == BANNER_W'(BANNER_FRAMES - 1));
    assign div_s         = 8'(BASE_DIV - (int'(level_q) - 1) * DIV_STEP);

    // Next-state and counter updates for the game flow.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        level_d  = level_q;
        score_d  = score_q;
        alive_d  = alive_q;
        banner_d = banner_q;
        wr_cnt_d = wr_cnt_q;
        case (state_q)
            ST_ATTRACT, ST_GAME_OVER, ST_VICTORY: begin
                if (fire_edge_s) begin
                    lives_d = 2'(START_LIVES);
                    level_d = 3'd1;
                    score_d = '0;
                    state_d = ST_WAVE_RESET;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAVE_RESET: begin
                alive_d = '1;
                if (wr_cnt_q) begin
                    wr_cnt_d = 1'b0;
                    state_d  = ST_PLAYING;
                end else begin
                    wr_cnt_d = 1'b1;
                end
            end
            ST_PLAYING: begin
                score_d = sat_add_score(score_q, SCORE_W'(kills_s));
                alive_d = index_aliens;
                if (alien_landed) begin
                    lives_d = lives_q - 2'd1;
                    state_d = ST_LIFE_LOST;
                end else if (index_aliens == '0) begin
                    state_d = ST_WAVE_CLEAR;
                end else begin
                    state_d = ST_PLAYING;
                end
            end
            ST_WAVE_CLEAR: begin
                if (banner_done_s) begin
                    banner_d = '0;
                    if (level_q == 3'(MAX_LEVEL)) begin
                        state_d = ST_VICTORY;
                    end else begin
                        level_d = level_q + 3'd1;
                        state_d = ST_WAVE_RESET;
                    end
                end else if (frame_tick) begin
                    banner_d = banner_q + BANNER_W'(1);
                end else begin
                    banner_d = banner_q;
                end
            end
            ST_LIFE_LOST: begin
                // Last life gone: skip the banner entirely.
                if (lives_q == 2'd0) begin
                    state_d = ST_GAME_OVER;
                end else if (banner_done_s) begin
                    banner_d = '0;
                    state_d  = ST_WAVE_RESET;
                end else if (frame_tick) begin
                    banner_d = banner_q + BANNER_W'(1);
                end else begin
                    banner_d = banner_q;
                end
            end
            default: begin
                state_d = ST_ATTRACT;
            end
        endcase
    end

    // Core state and bookkeeping registers.
    always_ff @(posedge master_clk or negedge d_reset_n) begin
        if (!d_reset_n) begin
            state_q  <= ST_ATTRACT;
            lives_q  <= 2'd0;
            level_q  <= 3'd1;
            score_q  <= '0;
            alive_q  <= '1;
            banner_q <= '0;
            wr_cnt_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            level_q  <= level_d;
            score_q  <= score_d;
            alive_q  <= alive_d;
            banner_q <= banner_d;
            wr_cnt_q <= wr_cnt_d;
            fire_q   <= d_fire;
        end
    end

    // Registered outputs, decoded from the state one cycle after it is entered.
    always_ff @(posedge master_clk or negedge d_reset_n) begin
        if (!d_reset_n) begin
            wave_rst_q   <= 1'b1;
            play_en_q    <= 1'b0;
            level_out_q  <= 3'd1;
            alien_div_q  <= 8'(BASE_DIV);
            lives_out_q  <= 2'd0;
            score_out_q  <= '0;
            game_over_q  <= 1'b0;
            victory_q    <= 1'b0;
            state_code_q <= ST_ATTRACT;
        end else begin
            wave_rst_q   <= (state_q == ST_ATTRACT) || (state_q == ST_WAVE_RESET);
            play_en_q    <= (state_q == ST_PLAYING);
            level_out_q  <= level_q;
            alien_div_q  <= div_s;
            lives_out_q  <= lives_q;
            score_out_q  <= score_q;
            game_over_q  <= (state_q == ST_GAME_OVER);
            victory_q    <= (state_q == ST_VICTORY);
            state_code_q <= state_q;
        end
    end

    assign wave_rst    = wave_rst_q;
    assign play_en     = play_en_q;
    assign level       = level_out_q;
    assign alien_div   = alien_div_q;
    assign lives       = lives_out_q;
    assign total_score = score_out_q;
    assign game_over   = game_over_q;
    assign victory     = victory_q;
    assign state_code  = state_code_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: hand-derived vector table, directed corner
// sequences and random stimulus against a phase-level reference model.
module tb_game_sequencer;

    logic       master_clk = 1'b0;
    logic       d_reset_n, d_fire, frame_tick, alien_landed;
    logic [5:0] index_aliens;
    logic       wave_rst, play_en, game_over, victory;
    logic [2:0] level, state_code;
    logic [7:0] alien_div, total_score;
    logic [1:0] lives;

    game_sequencer dut (
        .master_clk   (master_clk),
        .d_reset_n    (d_reset_n),
        .d_fire       (d_fire),
        .frame_tick   (frame_tick),
        .index_aliens (index_aliens),
        .alien_landed (alien_landed),
        .wave_rst     (wave_rst),
        .play_en      (play_en),
        .level        (level),
        .alien_div    (alien_div),
        .lives        (lives),
        .total_score  (total_score),
        .game_over    (game_over),
        .victory      (victory),
        .state_code   (state_code)
    );

    always #5 master_clk = ~master_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase (0..6), counters as plain integers.
    int         mst, mlives, mlevel, mscore, mban, mwr;
    logic [5:0] malive;
    bit         mfire_prev;
    int         e_state, e_wrst, e_play, e_level, e_div, e_lives, e_score, e_go, e_vic;

    typedef struct {
        bit         fire;
        logic [5:0] aliens;
        int         st;
        int         play;
        int         wrst;
        int         lv;
        int         score;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mst = 0; mlives = 0; mlevel = 1; mscore = 0; mban = 0; mwr = 0;
        malive = 6'h3F; mfire_prev = 1'b0;
    endtask

    task automatic model_start();
        mlives = 3; mlevel = 1; mscore = 0; mst = 1; mwr = 0;
    endtask

    task automatic model_banner(input bit t, input int next_phase);
        if (t) begin
            mban++;
            if (mban == 120) begin
                mban = 0;
                mst  = next_phase;
            end
        end
    endtask

    task automatic model_edge(input bit f, input bit t, input logic [5:0] a, input bit l);
        bit fe;
        int k;
        e_state = mst;
        e_wrst  = (mst == 0 || mst == 1) ? 1 : 0;
        e_play  = (mst == 2) ? 1 : 0;
        e_level = mlevel;
        e_div   = 24 - (mlevel - 1) * 4;
        e_lives = mlives;
        e_score = mscore;
        e_go    = (mst == 5) ? 1 : 0;
        e_vic   = (mst == 6) ? 1 : 0;
        fe = f && !mfire_prev;
        mfire_prev = f;
        case (mst)
            0, 5, 6: if (fe) model_start();
            1: begin
                malive = 6'h3F;
                mwr++;
                if (mwr == 2) begin mwr = 0; mst = 2; end
            end
            2: begin
                k = $countones(malive & ~a);
                mscore = (mscore + k > 255) ? 255 : mscore + k;
                malive = a;
                if (l) begin mlives--; mst = 4; end
                else if (a == 6'h00) mst = 3;
            end
            3: begin
                if (mlevel == 4) model_banner(t, 6);
                else begin
                    model_banner(t, 1);
                    if (mst == 1) mlevel++;
                end
            end
            4: begin
                if (mlives == 0) mst = 5;
                else model_banner(t, 1);
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("state_code",  int'(state_code),  e_state);
        chk("wave_rst",    int'(wave_rst),    e_wrst);
        chk("play_en",     int'(play_en),     e_play);
        chk("level",       int'(level),       e_level);
        chk("alien_div",   int'(alien_div),   e_div);
        chk("lives",       int'(lives),       e_lives);
        chk("total_score", int'(total_score), e_score);
        chk("game_over",   int'(game_over),   e_go);
        chk("victory",     int'(victory),     e_vic);
    endtask

    task automatic step(input bit f, input bit t, input logic [5:0] a, input bit l);
        d_fire = f; frame_tick = t; index_aliens = a; alien_landed = l;
        @(posedge master_clk);
        model_edge(f, t, a, l);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        d_reset_n = 1'b0; d_fire = 1'b0; frame_tick = 1'b0;
        index_aliens = 6'h3F; alien_landed = 1'b0;
        repeat (2) @(negedge master_clk);
        d_reset_n = 1'b1;
        model_reset();
    endtask

    task automatic banner_wait(input bit f);
        for (int i = 0; i < 120; i++) step(f, 1'b1, 6'h00, 1'b0);
    endtask

    task automatic settle_play(input bit f);
        for (int i = 0; i < 4; i++) step(f, 1'b0, 6'h3F, 1'b0);
    endtask

    initial begin
        int         cnt;
        int         r;
        logic [5:0] m;

        tbl[0] = '{1'b0, 6'h3F, 0, 0, 1, 0, 0};
        tbl[1] = '{1'b1, 6'h3F, 0, 0, 1, 0, 0};
        tbl[2] = '{1'b1, 6'h3F, 1, 0, 1, 3, 0};
        tbl[3] = '{1'b0, 6'h3F, 1, 0, 1, 3, 0};
        tbl[4] = '{1'b0, 6'h3F, 2, 1, 0, 3, 0};
        tbl[5] = '{1'b0, 6'h2D, 2, 1, 0, 3, 0};
        tbl[6] = '{1'b0, 6'h00, 2, 1, 0, 3, 2};
        tbl[7] = '{1'b0, 6'h00, 3, 0, 0, 3, 6};
        tbl[8] = '{1'b0, 6'h00, 3, 0, 0, 3, 6};

        do_reset();
        chk("rst_state",    int'(state_code),  0);
        chk("rst_wave_rst", int'(wave_rst),    1);
        chk("rst_play_en",  int'(play_en),     0);
        chk("rst_level",    int'(level),       1);
        chk("rst_div",      int'(alien_div),   24);
        chk("rst_lives",    int'(lives),       0);
        chk("rst_score",    int'(total_score), 0);
        chk("rst_flags",    int'({game_over, victory}), 0);

        // Start, first wave with kills 2 then 4, wave clear.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].fire, 1'b0, tbl[i].aliens, 1'b0);
            chk("tbl_state", int'(state_code),  tbl[i].st);
            chk("tbl_play",  int'(play_en),     tbl[i].play);
            chk("tbl_wrst",  int'(wave_rst),    tbl[i].wrst);
            chk("tbl_lives", int'(lives),       tbl[i].lv);
            chk("tbl_score", int'(total_score), tbl[i].score);
        end

        // Banner then level 2 with exactly two wave-reset cycles.
        banner_wait(1'b0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 6'h3F, 1'b0);
            if (wave_rst) cnt++;
        end
        chk("wrst_cycles", cnt, 2);
        chk("lvl2_level", int'(level), 2);
        chk("lvl2_div",   int'(alien_div), 20);
        chk("lvl2_play",  int'(play_en), 1);

        // Landing and clear in the same cycle: life lost wins.
        step(1'b0, 1'b0, 6'h00, 1'b1);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("ll_state", int'(state_code), 4);
        chk("ll_lives", int'(lives), 2);
        chk("ll_level", int'(level), 2);
        banner_wait(1'b0);
        settle_play(1'b0);
        chk("ll_back_play", int'(state_code), 2);
        chk("ll_score_kept", int'(total_score), 12);

        // Lose remaining lives, last one with fire already held.
        step(1'b0, 1'b0, 6'h3F, 1'b1);
        banner_wait(1'b0);
        settle_play(1'b0);
        step(1'b1, 1'b0, 6'h3F, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 6'h3F, 1'b0);
        chk("go_state", int'(state_code), 5);
        chk("go_flag",  int'(game_over), 1);
        chk("go_lives", int'(lives), 0);
        step(1'b0, 1'b0, 6'h3F, 1'b0);
        step(1'b1, 1'b0, 6'h3F, 1'b0);
        settle_play(1'b1);
        chk("restart_state", int'(state_code), 2);
        chk("restart_lives", int'(lives), 3);
        chk("restart_score", int'(total_score), 0);

        // Clear levels 1-3, then saturate the score on level 4 and win.
        for (int lv = 1; lv <= 3; lv++) begin
            step(1'b0, 1'b0, 6'h00, 1'b0);
            banner_wait(1'b0);
            settle_play(1'b0);
        end
        chk("lvl4_level", int'(level), 4);
        chk("lvl4_div",   int'(alien_div), 12);
        while (mscore <= 245) begin
            step(1'b0, 1'b0, 6'h01, 1'b0);
            step(1'b0, 1'b0, 6'h3F, 1'b0);
        end
        r = 250 - mscore;
        if (r > 0) begin
            m = 6'h3F >> r;
            step(1'b0, 1'b0, m, 1'b0);
            step(1'b0, 1'b0, 6'h3F, 1'b0);
        end
        step(1'b0, 1'b0, 6'h3F, 1'b0);
        chk("score_250", int'(total_score), 250);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("score_sat", int'(total_score), 255);
        banner_wait(1'b0);
        step(1'b0, 1'b0, 6'h00, 1'b0);
        chk("vic_flag",  int'(victory), 1);
        chk("vic_state", int'(state_code), 6);
        chk("vic_play",  int'(play_en), 0);
        step(1'b1, 1'b0, 6'h3F, 1'b0);
        settle_play(1'b0);
        chk("vic_restart", int'(state_code), 2);

        // Random play against the model.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F,
                 $urandom_range(0, 63) == 0);
        end

        // Asynchronous reset between clock edges in the middle of a wave.
        do_reset();
        step(1'b1, 1'b0, 6'h3F, 1'b0);
        settle_play(1'b0);
        step(1'b0, 1'b0, 6'h3E, 1'b0);
        step(1'b0, 1'b0, 6'h3E, 1'b0);
        chk("pre_rst_score", int'(total_score), 1);
        #3;
        d_reset_n = 1'b0;
        #1;
        chk("arst_wave_rst", int'(wave_rst), 1);
        chk("arst_play_en",  int'(play_en), 0);
        chk("arst_score",    int'(total_score), 0);
        chk("arst_state",    int'(state_code), 0);
        chk("arst_lives",    int'(lives), 0);
        model_reset();
        @(negedge master_clk);
        d_reset_n = 1'b1;
        step(1'b0, 1'b0, 6'h3F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
